// File: rtl/seq_gen_param_if.sv
// Control and data bundle for the multi-mode sequence generator.
// The master side drives control and table writes; the slave side returns out/wrap.
interface seq_gen_param_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] taps;
  logic [IW:0]      tbl_len;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] out;
  logic             wrap;

  modport master (
    output en, mode, load, seed, taps, tbl_len, wr_en, wr_addr, wr_data,
    input  out, wrap
  );

  modport slave (
    input  en, mode, load, seed, taps, tbl_len, wr_en, wr_addr, wr_data,
    output out, wrap
  );
endinterface

// File: rtl/seq_gen_param.sv
// Multi-mode sequence generator: binary, Gray, Galois LFSR and table playback.
// All outputs are decoded from registered state only; one step per enabled clock.
module seq_gen_param #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_gen_param_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_TBL  = 2'b11;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] lfsr_reg, lfsr_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [1:0]       mode_reg;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] tbl_reg [DEPTH];

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] lfsr_step;
  logic [IW:0]      len_eff;
  logic [IW:0]      idx_inc;

  // Each table entry is its own register so the whole table can clear on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (bus.wr_en && (bus.wr_addr == IW'(gi))) begin
          entry_reg <= bus.wr_data;
        end
      end
      assign tbl_reg[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    start_val = bus.load ? bus.seed : seed_reg;
    seed_eff  = (seed_reg == '0) ? WIDTH'(1) : seed_reg;

    lfsr_step = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? bus.taps : '0);
    if (lfsr_step == '0) begin
      lfsr_step = WIDTH'(1);
    end

    if (bus.tbl_len == '0) begin
      len_eff = (IW+1)'(1);
    end else if (bus.tbl_len > (IW+1)'(DEPTH)) begin
      len_eff = (IW+1)'(DEPTH);
    end else begin
      len_eff = bus.tbl_len;
    end
    idx_inc = {1'b0, idx_reg} + (IW+1)'(1);
  end

  always_comb begin
    cnt_next  = cnt_reg;
    lfsr_next = lfsr_reg;
    seed_next = seed_reg;
    idx_next  = idx_reg;
    wrap_next = 1'b0;

    // Load and a mode switch share one restart path; only load captures a new seed.
    if (bus.load || (bus.mode != mode_reg)) begin
      cnt_next  = start_val;
      lfsr_next = (start_val == '0) ? WIDTH'(1) : start_val;
      idx_next  = '0;
      if (bus.load) begin
        seed_next = bus.seed;
      end
    end else if (bus.en) begin
      case (mode_reg)
        MODE_BIN, MODE_GRAY: begin
          cnt_next  = cnt_reg + WIDTH'(1);
          wrap_next = (cnt_reg == '1);
        end
        MODE_LFSR: begin
          lfsr_next = lfsr_step;
          wrap_next = (lfsr_step == seed_eff);
        end
        default: begin
          if (idx_inc < len_eff) begin
            idx_next = idx_inc[IW-1:0];
          end else begin
            idx_next  = '0;
            wrap_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      lfsr_reg <= WIDTH'(1);
      seed_reg <= '0;
      idx_reg  <= '0;
      mode_reg <= MODE_BIN;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      lfsr_reg <= lfsr_next;
      seed_reg <= seed_next;
      idx_reg  <= idx_next;
      mode_reg <= bus.mode;
      wrap_reg <= wrap_next;
    end
  end

  always_comb begin
    case (mode_reg)
      MODE_BIN:  bus.out = cnt_reg;
      MODE_GRAY: bus.out = cnt_reg ^ (cnt_reg >> 1);
      MODE_LFSR: bus.out = lfsr_reg;
      default:   bus.out = tbl_reg[idx_reg];
    endcase
  end

  assign bus.wrap = wrap_reg;
endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised multi-mode sequence generator. It is the next generation of the fixed 3-bit sequence generator.
- Produces a WIDTH-bit output sequence that advances one step per enabled clock.
- Four selectable modes: binary count, Gray count, Galois LFSR, programmable table playback.
- Used as a stimulus/pattern source and as a tick/sequence driver for downstream datapath blocks.

Parameters:
WIDTH, 3, output and state width in bits (>=2)
DEPTH, 8, table entries (power of 2, >=2); IW = log2(DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance sequence one step this cycle
mode  input  2  00 binary, 01 Gray, 10 LFSR, 11 table
load  input  1  load seed / restart sequence
seed  input  WIDTH  start value for binary/Gray/LFSR
taps  input  WIDTH  LFSR feedback mask
tbl_len  input  IW+1  active table entries, 1..DEPTH
wr_en  input  1  table write strobe
wr_addr  input  IW  table write address
wr_data  input  WIDTH  table write data
out  output  WIDTH  current sequence element
wrap  output  1  one-cycle pulse: sequence returned to start

Behaviour:
- State registers: cnt[WIDTH], lfsr[WIDTH], idx[IW], seed_q[WIDTH], mode_q[2], wrap register, tbl[DEPTH][WIDTH].
- out is combinational from registered state and mode_q:
  - binary: cnt
  - Gray: cnt ^ (cnt>>1)
  - LFSR: lfsr
  - table: tbl[idx]
- Every input effect is therefore visible on out one cycle after the sampling edge.
- Reset values: cnt=0, lfsr=1, idx=0, seed_q=0, mode_q=00, wrap=0, all tbl entries=0. out=0 after reset.
- mode_q <= mode every cycle.
- Control priority per cycle: rst > load > mode change (mode != mode_q) > en.
- load and mode-change restart both apply the same update, and neither steps the sequence that cycle:
  - cnt <= start value
  - lfsr <= start value, or 1 if the start value is 0
  - idx <= 0
  - wrap <= 0
  - load also captures seed_q <= seed. The start value is seed on load, seed_q on mode change.
- Step (en=1, no higher-priority event), per mode:
  - binary/Gray: cnt <= cnt+1 mod 2^WIDTH. wrap <= 1 when cnt was all-ones.
  - LFSR (Galois, right shift): lfsr <= (lfsr>>1) ^ (lfsr[0] ? taps : 0).
    - If the result is 0, load 1 instead (lock-up guard).
    - wrap <= 1 when the next value equals the effective seed (seed_q, or 1 if seed_q=0).
  - table: let len_eff = max(tbl_len,1), clamped to DEPTH.
    - idx <= idx+1 if idx+1 < len_eff, else 0 with wrap <= 1.
    - If tbl_len shrinks below the current idx, the next step goes to 0 with wrap.
- en=0: state holds, wrap <= 0.
- wrap is high exactly one cycle, concurrent with out showing the first element.
- Table write is independent of mode, en and load: wr_en writes tbl[wr_addr] <= wr_data.
  - A write to the currently displayed idx shows the new data on out the next cycle.
  - A write and a step in the same cycle both take effect.
- rst mid-sequence forces reset values on the next edge regardless of any other input. Table contents are cleared.
- No combinational path from any input to out. Only the registered state feeds out.

Test Plan:
1. WIDTH=3, mode 00, seed 0, load, then en=1 for 9 cycles -> out 0,1,2,3,4,5,6,7,0; wrap=1 only with the second 0.
2. Mode 01, en=1 -> out 000,001,011,010,110,111,101,100,000; wrap with the return to 000.
3. Mode 10, taps=110, seed=001, load, en=1 -> out 001,110,011,111,101,100,010,001; period 7, wrap on the return to 001. With seed=000, out starts at 001.
4. Mode 11, write tbl[0..4]=5,2,7,0,3, tbl_len=5, load, en=1 -> out 5,2,7,0,3,5; wrap with the second 5. Then tbl_len=0 -> out holds repeating tbl[0] with wrap every step.
5. Priority: binary at cnt=4, assert load (seed=6) and en together -> out=6, no step. Next en -> 7. Change mode 00->01 with en=1 -> out=Gray(6)=101, no step.
6. Reset mid-sequence (binary at 5, table loaded) with rst=1, en=1, load=1 -> next cycle out=0, wrap=0, mode_q=00. Switching to mode 11 shows 0 (table cleared).
